// File: rtl/onehot_seq_pkg.sv
// Shared definitions for the one-hot step sequencer: the control state
// enumeration, its encoding width, and the default geometry that the
// factorial calculator top uses (3-bit step code, 7 stage enables).
package onehot_seq_pkg;

  // Width of the state encoding; three states fit in two bits.
  localparam int STATE_W = 2;

  // Default geometry used by the calculator top.
  localparam int DEFAULT_SEL_W   = 3;
  localparam int DEFAULT_NUM_OUT = 7;

  // IDLE: no step selected, all enables low.
  // ACTIVE: a legal step is selected and its enable is driven.
  // ERROR: an out-of-range code was loaded; enables stay low.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

endpackage : onehot_seq_pkg

// File: rtl/onehot_step_decode.sv
// Purely combinational index-to-one-hot decoder with an enable.
// Every output bit is a plain equality/compare against a constant, so an
// out-of-range index simply yields all zeros rather than unknowns.
// Optional thermometer output when ONEHOT_STEP_SEQUENCER_THERMO_EN is defined.
module onehot_step_decode #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 7
) (
  input  logic [SEL_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_OUT-1:0] onehot
`ifdef ONEHOT_STEP_SEQUENCER_THERMO_EN
  ,
  output logic [NUM_OUT-1:0] thermo
`endif
);

  // One line per output: line gi is set only when enabled and idx equals gi.
  // The thermometer line gi is set for every idx at or above gi.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_line
    assign onehot[gi] = en && (idx == SEL_W'(gi));
`ifdef ONEHOT_STEP_SEQUENCER_THERMO_EN
    assign thermo[gi] = en && (idx >= SEL_W'(gi));
`endif
  end

endmodule : onehot_step_decode

// File: rtl/onehot_step_sequencer.sv
// Registered one-hot control-step sequencer.
// Holds the current step index and advances it on a step strobe, wrapping
// (WRAP=1) or terminating back to IDLE (WRAP=0) after the last step.
// Loading a code outside 0..NUM_OUT-1 parks the block in ERROR with all
// enables low. Priority each cycle: clear, then load, then step.
// Optional feature macro: ONEHOT_STEP_SEQUENCER_THERMO_EN adds a registered
// thermometer output alongside the one-hot output.
module onehot_step_sequencer
  import onehot_seq_pkg::*;
#(
  parameter int SEL_W   = DEFAULT_SEL_W,
  parameter int NUM_OUT = DEFAULT_NUM_OUT,
  parameter int WRAP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               step,
  output logic [NUM_OUT-1:0] onehot,
  output logic [SEL_W-1:0]   sel_q,
  output logic               active,
  output logic               invalid,
  output logic               last,
  output logic               wrap_p,
  output logic               done_p
`ifdef ONEHOT_STEP_SEQUENCER_THERMO_EN
  ,
  output logic [NUM_OUT-1:0] thermo
`endif
);

  // Reject geometries where the index cannot address every line, or where
  // fewer than two lines make a sequence meaningless.
  if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
    $error("onehot_step_sequencer: NUM_OUT must be within 2 .. 2**SEL_W");
  end

  // Index of the final step, and NUM_OUT widened by one bit so that the
  // range check still works when NUM_OUT == 2**SEL_W.
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);

  state_t               state_reg, state_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;
  logic [NUM_OUT-1:0]   onehot_reg, onehot_next;
  logic                 wrap_reg, wrap_next;
  logic                 done_reg, done_next;
  logic                 load_in_range;
  logic                 at_last;

  assign load_in_range = ({1'b0, sel_in} < NUM_OUT_W);
  assign at_last       = (sel_reg == LAST_IDX);

  // Next-state logic: clear beats load beats step; pulses default low.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    wrap_next  = 1'b0;
    done_next  = 1'b0;
    if (clear) begin
      state_next = ST_IDLE;
      sel_next   = '0;
    end else if (load) begin
      // The raw code is kept even when out of range so it can be inspected.
      sel_next   = sel_in;
      state_next = load_in_range ? ST_ACTIVE : ST_ERROR;
    end else if (step) begin
      case (state_reg)
        ST_ACTIVE: begin
          if (at_last) begin
            // Increment is modulo NUM_OUT: the step after the last is 0.
            sel_next = '0;
            if (WRAP != 0) begin
              wrap_next = 1'b1;
            end else begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            sel_next = sel_reg + SEL_W'(1);
          end
        end
        // Steps are ignored while idle or holding an invalid code.
        default: begin
          state_next = state_reg;
          sel_next   = sel_reg;
        end
      endcase
    end
  end

  // Decode the upcoming step so the registered one-hot lines up with sel_q.
`ifdef ONEHOT_STEP_SEQUENCER_THERMO_EN
  logic [NUM_OUT-1:0] thermo_reg, thermo_next;

  onehot_step_decode #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_decode (
    .idx    (sel_next),
    .en     (state_next == ST_ACTIVE),
    .onehot (onehot_next),
    .thermo (thermo_next)
  );

  // Thermometer register shares the one-hot timing and reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thermo_reg <= '0;
    end else begin
      thermo_reg <= thermo_next;
    end
  end

  assign thermo = thermo_reg;
`else
  onehot_step_decode #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_decode (
    .idx    (sel_next),
    .en     (state_next == ST_ACTIVE),
    .onehot (onehot_next)
  );
`endif

  // State, index, decoded lines and event pulses all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      onehot_reg <= '0;
      wrap_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      onehot_reg <= onehot_next;
      wrap_reg   <= wrap_next;
      done_reg   <= done_next;
    end
  end

  assign onehot  = onehot_reg;
  assign sel_q   = sel_reg;
  assign active  = (state_reg == ST_ACTIVE);
  assign invalid = (state_reg == ST_ERROR);
  assign last    = (state_reg == ST_ACTIVE) && at_last;
  assign wrap_p  = wrap_reg;
  assign done_p  = done_reg;

endmodule : onehot_step_sequencer

// File: doc/onehot_step_sequencer.md
# onehot_step_sequencer

Registered, parametrised one-hot control-step sequencer for the factorial calculator datapath. It generalises the fixed 3-bit to 7-line one-hot decode into a block with configurable select width and output count. It holds the current step in a register and advances it on a step strobe, with either wrap or terminate-at-end mode. Out-of-range codes are flagged explicitly instead of driving unknown outputs. The calculator control FSM uses it to drive per-stage enables.

## Interface
Parameters:
- SEL_W, default 3: width of step index and load code.
- NUM_OUT, default 7: number of one-hot lines. Legal range is 2 to 2^SEL_W; elaboration fails outside this range.
- WRAP, default 1: 1 means the last step wraps to 0; 0 means the last step terminates the sequence.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous return to IDLE; highest priority.
- load, in, 1: load sel_in as the current step.
- sel_in, in, SEL_W: step code sampled when load=1.
- step, in, 1: advance one step.
- onehot, out, NUM_OUT: registered one-hot of the current step; all zero unless the state is ACTIVE.
- sel_q, out, SEL_W: registered current step index.
- active, out, 1: high when the state is ACTIVE.
- invalid, out, 1: high when the state is ERROR.
- last, out, 1: high when active=1 and sel_q==NUM_OUT-1. Derived from registers only.
- wrap_p, out, 1: one-cycle pulse on a wrap from last to 0.
- done_p, out, 1: one-cycle pulse on termination when WRAP=0.

## Operation
- States: IDLE, ACTIVE, ERROR.
- Input priority each cycle: clear, then load, then step. A lower-priority input asserted in the same cycle is ignored.
- clear, from any state: go to IDLE with sel_q=0. No pulses.
- load with sel_in < NUM_OUT, from any state: go to ACTIVE with sel_q=sel_in.
- load with sel_in ≥ NUM_OUT, from any state: go to ERROR with sel_q=sel_in and onehot=0.
- step in IDLE or ERROR: ignored.
- step in ACTIVE with sel_q < NUM_OUT-1: sel_q increments by 1.
- step in ACTIVE with sel_q = NUM_OUT-1 and WRAP=1: sel_q becomes 0, state stays ACTIVE, wrap_p=1 for one cycle.
- step in ACTIVE with sel_q = NUM_OUT-1 and WRAP=0: state becomes IDLE, sel_q becomes 0, done_p=1 for one cycle.
- onehot = 1 << sel_q while ACTIVE. It is never X for any input code.
- Increment arithmetic is modulo NUM_OUT, not modulo 2^SEL_W.

## Timing
- All outputs are registered. Effects of clear, load, or step appear on the edge that samples them, so latency is one cycle.
- Reset values: state IDLE, onehot=0, sel_q=0, active=0, invalid=0, wrap_p=0, done_p=0, last=0.
- rst is asynchronous. Assertion in the middle of a sequence forces reset values immediately. Deassertion must be synchronous to clk at the system level.
- wrap_p and done_p are never high in the same cycle. Each is high for exactly one cycle per event.
- Holding step high advances one step per cycle, including back-to-back wraps.
- load and step in the same cycle: load wins and there is no increment.
- With NUM_OUT = 2^SEL_W, ERROR is unreachable and invalid stays 0.

## Configuration
- Macro: ONEHOT_STEP_SEQUENCER_THERMO_EN.
- When defined:
  - An extra output port thermo (out, NUM_OUT) is present.
  - It is registered, with thermo[i]=1 for all i ≤ sel_q while ACTIVE, and 0 otherwise.
  - Reset value is 0. Timing is identical to onehot.
- When undefined: the port and its register are absent. All other behaviour is unchanged.

## Structure
- Shared package onehot_seq_pkg holds:
  - the state enum (IDLE, ACTIVE, ERROR);
  - the state-encoding width constant;
  - the default SEL_W/NUM_OUT constants used by the calculator top.
- One sub-module, onehot_step_decode:
  - purely combinational;
  - maps an index plus an enable to one-hot (and thermometer when the macro is on);
  - its output is registered in the parent.

## Test plan
- Reset during ACTIVE with sel_q=4 (asynchronous, mid-cycle) → all outputs 0 immediately; state IDLE.
- Defaults, WRAP=1: load sel_in=5, then 3 steps → onehot 0100000, 1000000, 0000001, 0000010. wrap_p high only on the 1000000→0000001 edge.
- WRAP=0, NUM_OUT=7: load 6, then step → active=0, onehot=0, sel_q=0, done_p=1 for one cycle. A further step leaves IDLE unchanged.
- load sel_in=7 with defaults → invalid=1, onehot=0, sel_q=7. step is ignored. load 2 → active=1, onehot=0000100, invalid=0.
- Simultaneous clear+load+step while ACTIVE at 3 → IDLE, sel_q=0. load+step at 3 with sel_in=1 → onehot=0000010.
- With the THERMO macro, SEL_W=4, NUM_OUT=10: load 3 → thermo=0000001111. step ×6 → last=1, thermo all ones.
